// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - ID->EX operand stage: regfile addressing, RAW forwarding/stall, ID/EX register
// Optional feature: FORWARD_EN (EX/MEM and MEM/WB forwarding; otherwise scoreboard interlock).
module id_operand_stage #(
    parameter int CTRL_W      = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic                   in_use_rs1,
    input  logic                   in_use_rs2,
    input  logic [4:0]             in_rd,
    input  logic                   in_rd_we,
    input  logic                   in_is_load,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_imm,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    input  logic [31:0]            rs1_data,
    input  logic [31:0]            rs2_data,
    input  logic                   ex_valid,
    input  logic                   ex_rd_we,
    input  logic                   ex_is_load,
    input  logic [4:0]             ex_rd,
    input  logic [31:0]            ex_result,
    input  logic                   mem_valid,
    input  logic                   mem_rd_we,
    input  logic [4:0]             mem_rd,
    input  logic [31:0]            mem_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_op1,
    output logic [31:0]            out_op2,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_imm,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [4:0]             out_rd,
    output logic                   out_rd_we,
    output logic                   out_is_load,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    function automatic logic match(input logic [4:0] r, input logic [4:0] rd,
                                   input logic we, input logic v);
        return v & we & (rd != 5'd0) & (rd == r);
    endfunction

    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_op1_q, out_op1_d, out_op2_q, out_op2_d;
    logic [31:0]            out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [CTRL_W-1:0]      out_ctrl_q, out_ctrl_d;
    logic [4:0]             out_rd_q, out_rd_d;
    logic                   out_rd_we_q, out_rd_we_d, out_is_load_q, out_is_load_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        own_hz, ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic        hazard, capture;
    logic [31:0] op1, op2;

    assign rs1 = in_rs1;
    assign rs2 = in_rs2;

    // The ID/EX occupant has not executed yet, so nothing can be forwarded from it.
    always_comb begin
        own_hz   = (in_use_rs1 & match(in_rs1, out_rd_q, out_rd_we_q, out_valid_q))
                 | (in_use_rs2 & match(in_rs2, out_rd_q, out_rd_we_q, out_valid_q));
        ex_hit1  = match(in_rs1, ex_rd, ex_rd_we, ex_valid);
        ex_hit2  = match(in_rs2, ex_rd, ex_rd_we, ex_valid);
        mem_hit1 = match(in_rs1, mem_rd, mem_rd_we, mem_valid);
        mem_hit2 = match(in_rs2, mem_rd, mem_rd_we, mem_valid);
    end

`ifdef FORWARD_EN
    always_comb begin
        hazard = own_hz | (ex_is_load & ((in_use_rs1 & ex_hit1) | (in_use_rs2 & ex_hit2)));
        op1 = (in_rs1 == 5'd0) ? 32'd0 : ex_hit1 ? ex_result : mem_hit1 ? mem_result : rs1_data;
        op2 = (in_rs2 == 5'd0) ? 32'd0 : ex_hit2 ? ex_result : mem_hit2 ? mem_result : rs2_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load, ex_result, mem_result};

    always_comb begin
        hazard = own_hz | (in_use_rs1 & (ex_hit1 | mem_hit1))
                        | (in_use_rs2 & (ex_hit2 | mem_hit2));
        op1 = (in_rs1 == 5'd0) ? 32'd0 : rs1_data;
        op2 = (in_rs2 == 5'd0) ? 32'd0 : rs2_data;
    end
`endif

    assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_pc_d      = out_pc_q;
        out_imm_d     = out_imm_q;
        out_ctrl_d    = out_ctrl_q;
        out_rd_d      = out_rd_q;
        out_rd_we_d   = out_rd_we_q;
        out_is_load_d = out_is_load_q;
        stall_cnt_d   = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d   = 1'b1;
            out_op1_d     = op1;
            out_op2_d     = op2;
            out_pc_d      = in_pc;
            out_imm_d     = in_imm;
            out_ctrl_d    = in_ctrl;
            out_rd_d      = in_rd;
            out_rd_we_d   = in_rd_we;
            out_is_load_d = in_is_load;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && hazard && !flush && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_pc_q      <= '0;
            out_imm_q     <= '0;
            out_ctrl_q    <= '0;
            out_rd_q      <= '0;
            out_rd_we_q   <= 1'b0;
            out_is_load_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_pc_q      <= out_pc_d;
            out_imm_q     <= out_imm_d;
            out_ctrl_q    <= out_ctrl_d;
            out_rd_q      <= out_rd_d;
            out_rd_we_q   <= out_rd_we_d;
            out_is_load_q <= out_is_load_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_pc      = out_pc_q;
    assign out_imm     = out_imm_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_rd      = out_rd_q;
    assign out_rd_we   = out_rd_we_q;
    assign out_is_load = out_is_load_q;
    assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - scoreboard testbench for id_operand_stage
module tb_id_operand_stage;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [31:0] LD_DATA = 32'hcafe_0007;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush, in_valid, in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_pc, in_imm, rs1_data, rs2_data;
    logic [15:0] in_ctrl;
    logic        ex_valid, ex_rd_we, ex_is_load, mem_valid, mem_rd_we, out_ready;
    logic [4:0]  ex_rd, mem_rd;
    logic [31:0] ex_result, mem_result;
    logic        in_ready, out_valid, out_rd_we, out_is_load;
    logic [4:0]  rs1, rs2, out_rd;
    logic [31:0] out_op1, out_op2, out_pc, out_imm;
    logic [15:0] out_ctrl;
    logic [31:0] stall_cnt;
    logic        unused_ready_s, unused_valid_s, unused_we_s, unused_ld_s;
    logic [4:0]  unused_rs1_s, unused_rs2_s, unused_rd_s;
    logic [31:0] unused_op1_s, unused_op2_s, unused_pc_s, unused_imm_s;
    logic [15:0] unused_ctrl_s;
    logic [3:0]  stall_cnt_s;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_operand_stage #(.CTRL_W(16), .STALL_CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_pc(in_pc),
        .in_imm(in_imm), .in_ctrl(in_ctrl), .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .ex_valid(ex_valid), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result), .mem_valid(mem_valid), .mem_rd_we(mem_rd_we),
        .mem_rd(mem_rd), .mem_result(mem_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_pc(out_pc), .out_imm(out_imm),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .stall_cnt(stall_cnt)
    );

    id_operand_stage #(.CTRL_W(16), .STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(unused_ready_s),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_pc(in_pc),
        .in_imm(in_imm), .in_ctrl(in_ctrl), .rs1(unused_rs1_s), .rs2(unused_rs2_s),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_valid(ex_valid), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result), .mem_valid(mem_valid),
        .mem_rd_we(mem_rd_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .out_valid(unused_valid_s), .out_ready(out_ready), .out_op1(unused_op1_s),
        .out_op2(unused_op2_s), .out_pc(unused_pc_s), .out_imm(unused_imm_s),
        .out_ctrl(unused_ctrl_s), .out_rd(unused_rd_s), .out_rd_we(unused_we_s),
        .out_is_load(unused_ld_s), .stall_cnt(stall_cnt_s)
    );

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; in_use_rs1 = 1'b0; in_use_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd_we = 1'b0; ex_is_load = 1'b0;
        mem_valid = 1'b0; mem_rd_we = 1'b0; out_ready = 1'b1;
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                             input logic u2, input logic [4:0] rd, input logic we,
                             input logic ld, input logic [31:0] pc);
        in_valid = 1'b1; in_rs1 = r1; in_use_rs1 = u1; in_rs2 = r2; in_use_rs2 = u2;
        in_rd = rd; in_rd_we = we; in_is_load = ld; in_pc = pc;
        in_imm = pc ^ 32'h5a5a_5a5a; in_ctrl = pc[15:0];
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== 32'd0)
            $display("FAIL reset_state: out_valid=%b stall_cnt=%0d want 0/0", out_valid, stall_cnt);
        else n_pass++;
        n_total++;
        if ({out_op1, out_op2, out_pc, out_imm, out_ctrl, out_rd, out_rd_we, out_is_load} !== '0)
            $display("FAIL reset_fields: op1=%h pc=%h ctrl=%h want 0", out_op1, out_pc, out_ctrl);
        else n_pass++;
        rst_n = 1'b1;
        idle();
        out_ready = 1'b0;
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 32'h40);
        sb.push_back('{op1: 32'd0, op2: 32'd0, pc: 32'h40});
        @(negedge clk);
        rs1_data = 32'h1111;
        set_instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h44);
        sb.push_back('{op1: 32'h1111, op2: 32'd0, pc: 32'h44});
        repeat (2) @(negedge clk);
        n_total++;
        if (stall_cnt !== 32'd2) $display("FAIL reset_prestall: stall_cnt=%0d want 2", stall_cnt);
        else n_pass++;
        #2 rst_n = 1'b0;
        e = sb.pop_front();
        #1;
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== 32'd0)
            $display("FAIL reset_async: out_valid=%b stall_cnt=%0d want 0/0", out_valid, stall_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: in_ready=%b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
        idle();
        n_total++;
        if (out_valid === 1'b1 && sb.size() > 0) begin n_pass++; e = sb.pop_front(); end
        else begin e = '0; $display("FAIL reset_capture: out_valid=%b queued=%0d want 1", out_valid, sb.size()); end
        n_total++;
        if (out_op1 !== e.op1 || out_pc !== e.pc)
            $display("FAIL reset_op1: op1=%h pc=%h want %h/%h", out_op1, out_pc, e.op1, e.pc);
        else n_pass++;
    endtask

    task automatic test_forward();
        int stalls;
        logic [31:0] c0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle();
            @(negedge clk);
            ex_valid = 1'b1; ex_rd_we = 1'b1; ex_rd = (k == 0) ? 5'd5 : 5'd6;
            ex_result = (k == 0) ? 32'haa : 32'hcc;
            mem_valid = 1'b1; mem_rd_we = 1'b1; mem_rd = 5'd5; mem_result = 32'hbb;
            rs1_data = 32'h11; rs2_data = 32'h99;
            set_instr((k == 0) ? 5'd5 : 5'd6, 1'b1, (k == 0) ? 5'd9 : 5'd5, 1'b1,
                      5'd14, 1'b1, 1'b0, 32'h600 + 32'(k));
            sb.push_back('{op1: FWD ? ((k == 0) ? 32'haa : 32'hcc) : 32'h11,
                           op2: (FWD && k == 1) ? 32'hbb : 32'h99, pc: 32'h600 + 32'(k)});
            c0 = stall_cnt;
            stalls = 0;
            #1;
            while (in_ready !== 1'b1 && stalls < 10) begin
                @(negedge clk);
                stalls++;
                ex_valid = 1'b0; mem_valid = 1'b0;
                #1;
            end
            n_total++;
            if (stalls != (FWD ? 0 : 1) || stall_cnt - c0 != (FWD ? 32'd0 : 32'd1))
                $display("FAIL fwd_stalls%0d: stalls=%0d cnt_delta=%0d want %0d", k, stalls,
                         stall_cnt - c0, FWD ? 0 : 1);
            else n_pass++;
            @(negedge clk);
            idle();
            n_total++;
            if (out_valid === 1'b1 && sb.size() > 0) begin n_pass++; e = sb.pop_front(); end
            else begin e = '0; $display("FAIL fwd_valid%0d: out_valid=%b want 1", k, out_valid); end
            n_total++;
            if (out_op1 !== e.op1 || out_op2 !== e.op2 || out_pc !== e.pc)
                $display("FAIL fwd_ops%0d: op1=%h op2=%h want %h/%h", k, out_op1, out_op2, e.op1, e.op2);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        int stalls;
        logic [31:0] c0;
        @(negedge clk);
        idle();
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        n_total++;
        if ({out_valid, out_rd, out_rd_we, out_is_load} !== {1'b1, 5'd7, 1'b1, 1'b1})
            $display("FAIL lu_lw_held: valid=%b rd=%0d we=%b ld=%b want 1/7/1/1",
                     out_valid, out_rd, out_rd_we, out_is_load);
        else n_pass++;
        rs1_data = 32'h7777;
        set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 32'h104);
        sb.push_back('{op1: FWD ? LD_DATA : 32'h7777, op2: 32'd0, pc: 32'h104});
        c0 = stall_cnt;
        stalls = 0;
        #1;
        while (in_ready !== 1'b1 && stalls < 10) begin
            @(negedge clk);
            stalls++;
            if (stalls == 1) begin
                ex_valid = 1'b1; ex_rd = 5'd7; ex_rd_we = 1'b1; ex_is_load = 1'b1; ex_result = LD_DATA;
            end else if (stalls == 2) begin
                ex_valid = 1'b0; ex_is_load = 1'b0;
                mem_valid = 1'b1; mem_rd = 5'd7; mem_rd_we = 1'b1; mem_result = LD_DATA;
            end else begin
                mem_valid = 1'b0;
            end
            #1;
        end
        n_total++;
        if (stalls != (FWD ? 2 : 3)) $display("FAIL lu_stalls: stalls=%0d want %0d", stalls, FWD ? 2 : 3);
        else n_pass++;
        n_total++;
        if (stall_cnt - c0 != (FWD ? 32'd2 : 32'd3))
            $display("FAIL lu_stall_cnt: delta=%0d want %0d", stall_cnt - c0, FWD ? 2 : 3);
        else n_pass++;
        @(negedge clk);
        idle();
        n_total++;
        if (out_valid === 1'b1 && sb.size() > 0) begin n_pass++; e = sb.pop_front(); end
        else begin e = '0; $display("FAIL lu_valid: out_valid=%b want 1", out_valid); end
        n_total++;
        if (out_op1 !== e.op1 || out_pc !== e.pc)
            $display("FAIL lu_op1: op1=%h pc=%h want %h/%h", out_op1, out_pc, e.op1, e.pc);
        else n_pass++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle();
        @(negedge clk);
        ex_valid = 1'b1; ex_rd = 5'd0; ex_rd_we = 1'b1; ex_result = 32'h55;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_rd_we = 1'b1; mem_result = 32'h66;
        rs1_data = 32'h33; rs2_data = 32'hdead;
        set_instr(5'd3, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 32'h400);
        sb.push_back('{op1: 32'h33, op2: 32'd0, pc: 32'h400});
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL x0_no_stall: in_ready=%b want 1", in_ready);
        else n_pass++;
        n_total++;
        if ({rs1, rs2} !== {5'd3, 5'd0}) $display("FAIL x0_raddr: rs1=%0d rs2=%0d want 3/0", rs1, rs2);
        else n_pass++;
        @(negedge clk);
        idle();
        n_total++;
        if (out_valid === 1'b1 && sb.size() > 0) begin n_pass++; e = sb.pop_front(); end
        else begin e = '0; $display("FAIL x0_valid: out_valid=%b want 1", out_valid); end
        n_total++;
        if (out_op1 !== e.op1 || out_op2 !== e.op2 || out_imm !== (e.pc ^ 32'h5a5a_5a5a))
            $display("FAIL x0_ops: op1=%h op2=%h imm=%h want %h/%h", out_op1, out_op2, out_imm, e.op1, e.op2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle();
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_total++;
                if (out_valid === 1'b1 && sb.size() > 0) begin n_pass++; e = sb.pop_front(); end
                else begin e = '0; $display("FAIL b2b_valid%0d: out_valid=%b want 1", k, out_valid); end
                n_total++;
                if (out_op1 !== e.op1 || out_pc !== e.pc || out_ctrl !== e.pc[15:0])
                    $display("FAIL b2b_data%0d: op1=%h pc=%h ctrl=%h want %h/%h", k, out_op1, out_pc,
                             out_ctrl, e.op1, e.pc);
                else n_pass++;
            end
            if (k < 4) begin
                rs1_data = 32'h1000 + 32'(k);
                set_instr(5'(10 + k), 1'b1, 5'd0, 1'b0, 5'(20 + k), 1'b1, 1'b0, 32'h500 + 32'(4 * k));
                sb.push_back('{op1: 32'h1000 + 32'(k), op2: 32'd0, pc: 32'h500 + 32'(4 * k)});
                #1;
                n_total++;
                if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: in_ready=%b want 1", k, in_ready);
                else n_pass++;
            end else begin
                idle();
            end
        end
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL b2b_bubble: out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure_flush();
        logic [31:0] c0;
        @(negedge clk);
        idle();
        out_ready = 1'b0;
        rs1_data = 32'h2222;
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h200);
        sb.push_back('{op1: 32'h2222, op2: 32'd0, pc: 32'h200});
        @(negedge clk);
        c0 = stall_cnt;
        set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 32'h204);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: in_ready=%b want 0", k, in_ready);
            else n_pass++;
            if (k == 0) begin
                n_total++;
                if (out_valid === 1'b1 && sb.size() > 0) begin n_pass++; e = sb.pop_front(); end
                else begin e = '0; $display("FAIL bp_valid: out_valid=%b want 1", out_valid); end
            end
            n_total++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_op1 !== e.op1)
                $display("FAIL bp_hold%0d: valid=%b pc=%h op1=%h want 1/%h/%h", k, out_valid,
                         out_pc, out_op1, e.pc, e.op1);
            else n_pass++;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL flush_ready: in_ready=%b want 0", in_ready);
        else n_pass++;
        @(negedge clk);
        idle();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_valid: out_valid=%b want 0", out_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== c0)
            $display("FAIL flush_discard: out_valid=%b stall_cnt=%0d want 0/%0d", out_valid, stall_cnt, c0);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [31:0] c0;
        @(negedge clk);
        idle();
        out_ready = 1'b0;
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 32'h300);
        @(negedge clk);
        set_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 32'h304);
        c0 = stall_cnt;
        repeat (20) @(negedge clk);
        n_total++;
        if (stall_cnt_s !== 4'hf) $display("FAIL sat_w4: stall_cnt=%0d want 15", stall_cnt_s);
        else n_pass++;
        n_total++;
        if (stall_cnt - c0 != 32'd20) $display("FAIL sat_w32: delta=%0d want 20", stall_cnt - c0);
        else n_pass++;
        flush = 1'b1;
        @(negedge clk);
        idle();
        n_total++;
        if (stall_cnt - c0 != 32'd20 || stall_cnt_s !== 4'hf || out_valid !== 1'b0)
            $display("FAIL sat_flush: delta=%0d cnt4=%0d valid=%b want 20/15/0", stall_cnt - c0,
                     stall_cnt_s, out_valid);
        else n_pass++;
    endtask

    initial begin
        idle();
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0; in_is_load = 1'b0;
        in_pc = '0; in_imm = '0; in_ctrl = '0; rs1_data = '0; rs2_data = '0;
        ex_rd = '0; ex_result = '0; mem_rd = '0; mem_result = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_x0();
        test_back_to_back();
        test_backpressure_flush();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
